filter_scanline_param: RTL and testbench

//  Parametrised PNG scanline filter; successor to the fixed RGBA filter stage. Per start_i,

---
 rtl/filter_scanline_param_if.sv | 24 ++
 rtl/filter_scanline_param.sv | 225 ++++++++++++++++++++++
 tb/tb_filter_scanline_param.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/filter_scanline_param_if.sv
// Bus bundle for filter_scanline_param: raw pixel stream in (valid/ready) and filtered-data FIFO write port.
// The master modport is the filter's view; the slave modport is the surrounding pixel source / FIFO.
`timescale 1ns/1ps
interface filter_scanline_param_if #(
    parameter int PXL_WD = 32
);
    logic              pix_val;
    logic              pix_rdy;
    logic [PXL_WD-1:0] pix_dat;
    logic              flt_full;
    logic              flt_val;
    logic              flt_hdr;
    logic [PXL_WD-1:0] flt_dat;

    modport master (
        input  pix_val, pix_dat, flt_full,
        output pix_rdy, flt_val, flt_hdr, flt_dat
    );

    modport slave (
        output pix_val, pix_dat, flt_full,
        input  pix_rdy, flt_val, flt_hdr, flt_dat
    );
endinterface

// File: rtl/filter_scanline_param.sv
// Parametrised PNG scanline filter (None/Sub/Up/Avg/Paeth per byte lane) feeding the deflate FIFO.
// Optional feature macro FILTER_PAETH_EN: when undefined, type 4 runs as Up and the header reports 2.
`timescale 1ns/1ps
module filter_scanline_param #(
    parameter int BPP   = 4,
    parameter int MAX_W = 512,
    parameter int W_WD  = 10,
    parameter int H_WD  = 10
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [W_WD-1:0]      cfg_w_i,
    input  logic [H_WD-1:0]      cfg_h_i,
    input  logic [2:0]           cfg_typ_i,
    input  logic                 start_i,
    output logic                 done_o,
    filter_scanline_param_if.master bus
);
    localparam int PXL_WD = 8 * BPP;
    localparam int AW     = (MAX_W > 1) ? $clog2(MAX_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_PXL,
        S_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [W_WD-1:0]   w_reg;
    logic [W_WD-1:0]   x_reg;
    logic [H_WD-1:0]   h_reg;
    logic [H_WD-1:0]   row_reg;
    logic [2:0]        typ_reg;
    logic [2:0]        typ_next;
    logic [PXL_WD-1:0] left_reg;
    logic              out_val_reg;
    logic              out_hdr_reg;
    logic [PXL_WD-1:0] out_dat_reg;

    logic [PXL_WD-1:0] line_buf [MAX_W];

    logic              start_acc;
    logic              hdr_wr;
    logic              pix_acc;
    logic              pix_rdy;
    logic              last_pix;
    logic [PXL_WD-1:0] above;
    logic [PXL_WD-1:0] left_px;
    logic [PXL_WD-1:0] flt_px;

`ifdef FILTER_PAETH_EN
    logic [PXL_WD-1:0] above_left_reg;
    logic [PXL_WD-1:0] above_left;
`endif

    // Unsupported type codes collapse to None; Paeth falls back to Up when not built in.
    always_comb begin
        typ_next = cfg_typ_i;
`ifdef FILTER_PAETH_EN
        if (cfg_typ_i > 3'd4) begin
            typ_next = 3'd0;
        end
`else
        if (cfg_typ_i > 3'd4) begin
            typ_next = 3'd0;
        end else if (cfg_typ_i == 3'd4) begin
            typ_next = 3'd2;
        end
`endif
    end

    assign last_pix = (x_reg == (w_reg - W_WD'(1)));

    always_comb begin
        state_next = state_reg;
        start_acc  = 1'b0;
        hdr_wr     = 1'b0;
        pix_acc    = 1'b0;
        pix_rdy    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start_i) begin
                    start_acc  = 1'b1;
                    state_next = S_HDR;
                end
            end
            S_HDR: begin
                if (!bus.flt_full) begin
                    hdr_wr     = 1'b1;
                    state_next = (w_reg == '0) ? S_DONE : S_PXL;
                end
            end
            S_PXL: begin
                pix_rdy = !bus.flt_full;
                pix_acc = bus.pix_val && !bus.flt_full;
                if (pix_acc && last_pix) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Neighbour pixels: left/above-left are 0 at the row start, above/above-left are 0 on row 0.
    assign above   = (row_reg == '0) ? '0 : line_buf[x_reg[AW-1:0]];
    assign left_px = (x_reg == '0) ? '0 : left_reg;
`ifdef FILTER_PAETH_EN
    assign above_left = ((x_reg == '0) || (row_reg == '0)) ? '0 : above_left_reg;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < BPP; gi++) begin : g_lane
            logic [7:0] xv;
            logic [7:0] av;
            logic [7:0] bv;
            logic [7:0] pred;

            assign xv = bus.pix_dat[8*gi +: 8];
            assign av = left_px[8*gi +: 8];
            assign bv = above[8*gi +: 8];

`ifdef FILTER_PAETH_EN
            logic [7:0]        cv;
            logic signed [9:0] pa_s;
            logic signed [9:0] pb_s;
            logic signed [9:0] pc_s;
            logic [9:0]        pa;
            logic [9:0]        pb;
            logic [9:0]        pc;
            logic [7:0]        paeth;

            assign cv   = above_left[8*gi +: 8];
            assign pa_s = $signed({2'b00, bv}) - $signed({2'b00, cv});
            assign pb_s = $signed({2'b00, av}) - $signed({2'b00, cv});
            assign pc_s = $signed({2'b00, av}) + $signed({2'b00, bv}) - $signed({1'b0, cv, 1'b0});
            assign pa   = pa_s[9] ? 10'(-pa_s) : 10'(pa_s);
            assign pb   = pb_s[9] ? 10'(-pb_s) : 10'(pb_s);
            assign pc   = pc_s[9] ? 10'(-pc_s) : 10'(pc_s);
            assign paeth = ((pa <= pb) && (pa <= pc)) ? av : ((pb <= pc) ? bv : cv);
`endif

            always_comb begin
                pred = 8'h00;
                case (typ_reg)
                    3'd1:    pred = av;
                    3'd2:    pred = bv;
                    3'd3:    pred = 8'((9'(av) + 9'(bv)) >> 1);
`ifdef FILTER_PAETH_EN
                    3'd4:    pred = paeth;
`endif
                    default: pred = 8'h00;
                endcase
            end

            assign flt_px[8*gi +: 8] = xv - pred;
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg   <= S_IDLE;
            w_reg       <= '0;
            h_reg       <= '0;
            typ_reg     <= '0;
            x_reg       <= '0;
            row_reg     <= '0;
            left_reg    <= '0;
            out_val_reg <= 1'b0;
            out_hdr_reg <= 1'b0;
            out_dat_reg <= '0;
`ifdef FILTER_PAETH_EN
            above_left_reg <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            out_val_reg <= hdr_wr || pix_acc;
            out_hdr_reg <= hdr_wr;
            if (hdr_wr) begin
                out_dat_reg <= PXL_WD'(typ_reg);
            end else if (pix_acc) begin
                out_dat_reg <= flt_px;
            end
            if (start_acc) begin
                w_reg   <= cfg_w_i;
                h_reg   <= cfg_h_i;
                typ_reg <= typ_next;
            end
            if (hdr_wr) begin
                x_reg <= '0;
            end else if (pix_acc) begin
                x_reg <= x_reg + W_WD'(1);
            end
            if (pix_acc) begin
                left_reg <= bus.pix_dat;
`ifdef FILTER_PAETH_EN
                above_left_reg <= above;
`endif
            end
            if (state_reg == S_DONE) begin
                row_reg <= (row_reg >= (h_reg - H_WD'(1))) ? '0 : row_reg + H_WD'(1);
            end
        end
    end

    // Read-before-write: the filter above sees the previous row's pixel at x this cycle.
    always_ff @(posedge clk) begin
        if (pix_acc) begin
            line_buf[x_reg[AW-1:0]] <= bus.pix_dat;
        end
    end

    assign done_o      = (state_reg == S_DONE);
    assign bus.pix_rdy = pix_rdy;
    assign bus.flt_val = out_val_reg;
    assign bus.flt_hdr = out_hdr_reg;
    assign bus.flt_dat = out_dat_reg;

endmodule

// File: tb/tb_filter_scanline_param.sv
// Directed bench for filter_scanline_param (BPP=4): each row's beats are captured and compared to hand values.
`timescale 1ns/1ps
module tb_filter_scanline_param;
    logic        clk;
    logic        rstn;
    logic [9:0]  cfg_w;
    logic [9:0]  cfg_h;
    logic [2:0]  cfg_typ;
    logic        start;
    logic        done;

    int          n_checks;
    int          n_errors;
    int          done_cnt;
    int          stall_viol;
    logic        full_d;
    logic [32:0] beats[$];
    logic [31:0] px_q[$];
    logic [31:0] exp_q[$];

    filter_scanline_param_if #(.PXL_WD(32)) bus ();

    filter_scanline_param #(
        .BPP  (4),
        .MAX_W(512),
        .W_WD (10),
        .H_WD (10)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .cfg_w_i  (cfg_w),
        .cfg_h_i  (cfg_h),
        .cfg_typ_i(cfg_typ),
        .start_i  (start),
        .done_o   (done),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) full_d <= bus.flt_full;

    always @(negedge clk) begin
        if (bus.flt_val) begin
            beats.push_back({bus.flt_hdr, bus.flt_dat});
            $display("beat: hdr=%0b dat=%08h", bus.flt_hdr, bus.flt_dat);
            if (full_d) stall_viol++;
        end
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_row(input logic [2:0] typ, input int w, input int h);
        cfg_typ = typ;
        cfg_w   = 10'(w);
        cfg_h   = 10'(h);
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        beats.delete();
    endtask

    task automatic send_pix(input logic [31:0] d);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        bus.pix_val = 1'b1;
        bus.pix_dat = d;
        while (!ok && n < 100) begin
            #1;
            ok = bus.pix_rdy;
            @(negedge clk);
            n++;
        end
        bus.pix_val = 1'b0;
        if (!ok) check("pix_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_done(input string tag);
        int base;
        int n;
        base = done_cnt;
        n    = 0;
        while (done_cnt == base && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check({tag, "_done_pulses"}, 64'(done_cnt - base), 64'd1);
    endtask

    task automatic run_row(input logic [2:0] typ, input int w, input int h, input string tag);
        start_row(typ, w, h);
        foreach (px_q[i]) send_pix(px_q[i]);
        wait_done(tag);
        $display("row %s: typ=%0d w=%0d beats=%0d", tag, typ, w, beats.size());
    endtask

    task automatic check_row(input string tag, input logic [7:0] typ);
        logic [63:0] got;
        check({tag, "_beats"}, 64'(beats.size()), 64'(exp_q.size() + 1));
        got = (beats.size() > 0) ? 64'(beats[0]) : 64'hDEAD_DEAD_DEAD;
        check({tag, "_hdr"}, got, {31'd0, 1'b1, 24'd0, typ});
        foreach (exp_q[i]) begin
            got = (beats.size() > i + 1) ? 64'(beats[i+1]) : 64'hDEAD_DEAD_DEAD;
            check($sformatf("%s_px%0d", tag, i), got, {32'd0, exp_q[i]});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        done_cnt    = 0;
        stall_viol  = 0;
        rstn        = 1'b0;
        start       = 1'b0;
        cfg_w       = '0;
        cfg_h       = '0;
        cfg_typ     = '0;
        bus.pix_val = 1'b0;
        bus.pix_dat = '0;
        bus.flt_full = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_done", 64'(done), 64'd0);
        check("rst_val", 64'(bus.flt_val), 64'd0);
        check("rst_hdr", 64'(bus.flt_hdr), 64'd0);
        check("rst_dat", 64'(bus.flt_dat), 64'd0);
        check("rst_rdy", 64'(bus.pix_rdy), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Sub on row 0
        px_q  = '{32'h10203040, 32'h11213141};
        exp_q = '{32'h10203040, 32'h01010101};
        run_row(3'd1, 2, 1, "t1_sub");
        check_row("t1_sub", 8'd1);

        // Up: row 0 raw, identical row 1 all zero
        px_q  = '{32'h01020304, 32'h80FF0011, 32'hDEADBEEF};
        exp_q = '{32'h01020304, 32'h80FF0011, 32'hDEADBEEF};
        run_row(3'd2, 3, 2, "t2_up_r0");
        check_row("t2_up_r0", 8'd2);
        exp_q = '{32'h0, 32'h0, 32'h0};
        run_row(3'd2, 3, 2, "t2_up_r1");
        check_row("t2_up_r1", 8'd2);

        // Avg
        px_q  = '{32'h11111111, 32'hFFFFFFFF};
        exp_q = '{32'h11111111, 32'hF7F7F7F7};
        run_row(3'd3, 2, 2, "t3_avg_r0");
        check_row("t3_avg_r0", 8'd3);
        px_q  = '{32'h80808080, 32'hC0C0C0C0};
        exp_q = '{32'h78787878, 32'h01010101};
        run_row(3'd3, 2, 2, "t3_avg_r1");
        check_row("t3_avg_r1", 8'd3);

        // Paeth (or Up when not built in)
        px_q  = '{32'h18181818, 32'h20202020};
`ifdef FILTER_PAETH_EN
        exp_q = '{32'h18181818, 32'h08080808};
        run_row(3'd4, 2, 2, "t4_r0");
        check_row("t4_r0", 8'd4);
        px_q  = '{32'h10101010, 32'h20202020};
        exp_q = '{32'hF8F8F8F8, 32'h08080808};
        run_row(3'd4, 2, 2, "t4_r1");
        check_row("t4_r1", 8'd4);
`else
        exp_q = '{32'h18181818, 32'h20202020};
        run_row(3'd4, 2, 2, "t4_r0");
        check_row("t4_r0", 8'd2);
        px_q  = '{32'h10101010, 32'h20202020};
        exp_q = '{32'hF8F8F8F8, 32'h00000000};
        run_row(3'd4, 2, 2, "t4_r1");
        check_row("t4_r1", 8'd2);
`endif

        // FIFO almost-full stall mid-row, with a pixel offered the whole time
        stall_viol = 0;
        exp_q = '{32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404};
        start_row(3'd1, 4, 1);
        send_pix(32'h01010101);
        send_pix(32'h03030303);
        bus.flt_full = 1'b1;
        bus.pix_val  = 1'b1;
        bus.pix_dat  = 32'h06060606;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("t5_stall_rdy%0d", k), 64'(bus.pix_rdy), 64'd0);
            @(negedge clk);
        end
        bus.flt_full = 1'b0;
        send_pix(32'h06060606);
        send_pix(32'h0A0A0A0A);
        wait_done("t5_stall");
        check_row("t5_stall", 8'd1);
        check("t5_beats_while_full", 64'(stall_viol), 64'd0);

        // Empty scanline: header then done
        px_q.delete();
        exp_q.delete();
        run_row(3'd1, 0, 1, "t5_w0");
        check_row("t5_w0", 8'd1);

        // Row counter wraps after cfg_h rows
        px_q  = '{32'h55555555};
        exp_q = '{32'h55555555};
        run_row(3'd2, 1, 2, "t6_r0");
        check_row("t6_r0", 8'd2);
        px_q  = '{32'h66666666};
        exp_q = '{32'h11111111};
        run_row(3'd2, 1, 2, "t6_r1");
        check_row("t6_r1", 8'd2);
        px_q  = '{32'h77777777};
        exp_q = '{32'h77777777};
        run_row(3'd2, 1, 2, "t6_r2");
        check_row("t6_r2", 8'd2);

        // Reset mid-row: outputs clear, next row behaves as row 0
        start_row(3'd2, 3, 2);
        send_pix(32'h99999999);
        rstn = 1'b0;
        #1;
        check("t6_rst_done", 64'(done), 64'd0);
        check("t6_rst_val", 64'(bus.flt_val), 64'd0);
        check("t6_rst_hdr", 64'(bus.flt_hdr), 64'd0);
        check("t6_rst_dat", 64'(bus.flt_dat), 64'd0);
        check("t6_rst_rdy", 64'(bus.pix_rdy), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        px_q  = '{32'h12345678};
        exp_q = '{32'h12345678};
        run_row(3'd2, 1, 2, "t6_after_rst");
        check_row("t6_after_rst", 8'd2);

        // Out-of-range type runs as None
        px_q  = '{32'hABCDEF01};
        exp_q = '{32'hABCDEF01};
        run_row(3'd7, 1, 1, "t6_typ7");
        check_row("t6_typ7", 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
